// File: rtl/multi_edge_tick.sv
// Multi-channel glitch filter with programmable edge detect and one-cycle registered ticks.
// Each channel keeps a debounced level, a hold counter and a 4-state filter FSM.
module multi_edge_tick #(
  parameter int N      = 4,
  parameter int FILTER = 3
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [N-1:0]   in,
  input  logic [2*N-1:0] mode,
  output logic [N-1:0]   tick,
  output logic [N-1:0]   level,
  output logic           any_tick
);

  localparam int CW = $clog2(FILTER + 1);
  localparam logic [CW-1:0] LAST = CW'(FILTER - 1);

  typedef enum logic [1:0] {
    STABLE_LOW  = 2'd0,
    RISE_PEND   = 2'd1,
    STABLE_HIGH = 2'd2,
    FALL_PEND   = 2'd3
  } state_t;

  for (genvar i = 0; i < N; i++) begin : g_ch
    state_t          state_q;
    logic [CW-1:0]   cnt_q;
    logic            level_q;
    logic            tick_q;
    logic            accept;

    // Counter is 0 in the STABLE states, so FILTER=1 accepts on the first differing sample.
    assign accept = (cnt_q == LAST);

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        state_q <= STABLE_LOW;
        cnt_q   <= '0;
        level_q <= 1'b0;
        tick_q  <= 1'b0;
      end else begin
        tick_q <= 1'b0;
        case (state_q)
          STABLE_LOW, RISE_PEND: begin
            if (!in[i]) begin
              state_q <= STABLE_LOW;
              cnt_q   <= '0;
            end else if (accept) begin
              state_q <= STABLE_HIGH;
              cnt_q   <= '0;
              level_q <= 1'b1;
              tick_q  <= mode[2*i];
            end else begin
              state_q <= RISE_PEND;
              cnt_q   <= cnt_q + CW'(1);
            end
          end
          default: begin
            if (in[i]) begin
              state_q <= STABLE_HIGH;
              cnt_q   <= '0;
            end else if (accept) begin
              state_q <= STABLE_LOW;
              cnt_q   <= '0;
              level_q <= 1'b0;
              tick_q  <= mode[2*i+1];
            end else begin
              state_q <= FALL_PEND;
              cnt_q   <= cnt_q + CW'(1);
            end
          end
        endcase
      end
    end

    assign tick[i]  = tick_q;
    assign level[i] = level_q;
  end

  assign any_tick = |tick;

endmodule

// File: tb/tb_multi_edge_tick.sv
// Bench for multi_edge_tick: vector table plus hand-written reset and FILTER=1 sequences.
// Expected outputs go into a scoreboard queue at drive time and are popped after each edge.
module tb_multi_edge_tick;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] in3, in1;
  logic [7:0] mode3, mode1;
  logic [3:0] tick3, tick1, level3, level1;
  logic       any3, any1;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [3:0] in;
    logic [7:0] mode;
    logic [3:0] tick;
    logic [3:0] level;
  } vec_t;

  typedef struct {
    bit         sel;
    logic [3:0] tick;
    logic [3:0] level;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];

  multi_edge_tick #(.N(4), .FILTER(3)) u3 (
    .clk(clk), .reset(reset), .in(in3), .mode(mode3),
    .tick(tick3), .level(level3), .any_tick(any3)
  );

  multi_edge_tick #(.N(4), .FILTER(1)) u1 (
    .clk(clk), .reset(reset), .in(in1), .mode(mode1),
    .tick(tick1), .level(level1), .any_tick(any1)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, got no summary, required completion");
    $fatal(1, "watchdog");
  end

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic void add(input logic [3:0] i_v, input logic [7:0] m_v,
                              input logic [3:0] t_e, input logic [3:0] l_e);
    vec_t v;
    v.in = i_v; v.mode = m_v; v.tick = t_e; v.level = l_e;
    vecs.push_back(v);
  endfunction

  // Starts and ends at a falling edge; compares 1 time unit after the rising edge.
  task automatic step(input bit sel, input logic [3:0] i_v, input logic [7:0] m_v,
                      input logic [3:0] t_e, input logic [3:0] l_e, input string tag);
    exp_t e;
    if (!sel) begin
      in3 = i_v; mode3 = m_v;
    end else begin
      in1 = i_v; mode1 = m_v;
    end
    e.sel = sel; e.tick = t_e; e.level = l_e;
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    if (!e.sel) begin
      cmp({tag, " tick"},  {28'd0, tick3},  {28'd0, e.tick});
      cmp({tag, " level"}, {28'd0, level3}, {28'd0, e.level});
      cmp({tag, " any"},   {31'd0, any3},   {31'd0, |e.tick});
    end else begin
      cmp({tag, " tick"},  {28'd0, tick1},  {28'd0, e.tick});
      cmp({tag, " level"}, {28'd0, level1}, {28'd0, e.level});
      cmp({tag, " any"},   {31'd0, any1},   {31'd0, |e.tick});
    end
    @(negedge clk);
  endtask

  initial begin
    // reset release with ch0 already high, all modes both-edge
    add(4'h1, 8'hFF, 4'h0, 4'h0); add(4'h1, 8'hFF, 4'h0, 4'h0);
    add(4'h1, 8'hFF, 4'h1, 4'h1); add(4'h1, 8'hFF, 4'h0, 4'h1);
    add(4'h0, 8'hFF, 4'h0, 4'h1); add(4'h0, 8'hFF, 4'h0, 4'h1);
    add(4'h0, 8'hFF, 4'h1, 4'h0); add(4'h0, 8'hFF, 4'h0, 4'h0);
    // ch1 two-cycle glitch, then a real rise; rising-only so the fall is silent
    add(4'h2, 8'h55, 4'h0, 4'h0); add(4'h2, 8'h55, 4'h0, 4'h0);
    add(4'h0, 8'h55, 4'h0, 4'h0); add(4'h2, 8'h55, 4'h0, 4'h0);
    add(4'h2, 8'h55, 4'h0, 4'h0); add(4'h2, 8'h55, 4'h2, 4'h2);
    add(4'h2, 8'h55, 4'h0, 4'h2); add(4'h2, 8'h55, 4'h0, 4'h2);
    add(4'h0, 8'h55, 4'h0, 4'h2); add(4'h0, 8'h55, 4'h0, 4'h2);
    add(4'h0, 8'h55, 4'h0, 4'h0); add(4'h0, 8'h55, 4'h0, 4'h0);
    // ch2 falling-only
    add(4'h4, 8'h20, 4'h0, 4'h0); add(4'h4, 8'h20, 4'h0, 4'h0);
    add(4'h4, 8'h20, 4'h0, 4'h4); add(4'h4, 8'h20, 4'h0, 4'h4);
    add(4'h4, 8'h20, 4'h0, 4'h4); add(4'h4, 8'h20, 4'h0, 4'h4);
    add(4'h0, 8'h20, 4'h0, 4'h4); add(4'h0, 8'h20, 4'h0, 4'h4);
    add(4'h0, 8'h20, 4'h4, 4'h0); add(4'h0, 8'h20, 4'h0, 4'h0);
    // all channels together
    add(4'hF, 8'hFF, 4'h0, 4'h0); add(4'hF, 8'hFF, 4'h0, 4'h0);
    add(4'hF, 8'hFF, 4'hF, 4'hF); add(4'hF, 8'hFF, 4'h0, 4'hF);
    add(4'h0, 8'hFF, 4'h0, 4'hF); add(4'h0, 8'hFF, 4'h0, 4'hF);
    add(4'h0, 8'hFF, 4'hF, 4'h0); add(4'h0, 8'hFF, 4'h0, 4'h0);
    // mode switched 00 -> 01 mid-pend, then mode 00 level tracking
    add(4'h1, 8'h00, 4'h0, 4'h0); add(4'h1, 8'h01, 4'h0, 4'h0);
    add(4'h1, 8'h01, 4'h1, 4'h1); add(4'h1, 8'h01, 4'h0, 4'h1);
    add(4'h0, 8'h00, 4'h0, 4'h1); add(4'h0, 8'h00, 4'h0, 4'h1);
    add(4'h0, 8'h00, 4'h0, 4'h0); add(4'h0, 8'h00, 4'h0, 4'h0);

    reset = 1'b1;
    in3 = 4'h1; mode3 = 8'hFF;
    in1 = 4'h0; mode1 = 8'hFF;
    #1;
    cmp("reset tick",  {28'd0, tick3},  32'd0);
    cmp("reset level", {28'd0, level3}, 32'd0);
    cmp("reset any",   {31'd0, any3},   32'd0);
    repeat (3) @(negedge clk);
    reset = 1'b0;

    for (int k = 0; k < vecs.size(); k++)
      step(1'b0, vecs[k].in, vecs[k].mode, vecs[k].tick, vecs[k].level, $sformatf("v%0d", k));

    // reset during a pending rise, then a full fresh filter delay
    step(1'b0, 4'h1, 8'hFF, 4'h0, 4'h0, "rp1");
    step(1'b0, 4'h1, 8'hFF, 4'h0, 4'h0, "rp2");
    reset = 1'b1;
    #1;
    cmp("rst pend tick",  {28'd0, tick3},  32'd0);
    cmp("rst pend level", {28'd0, level3}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    step(1'b0, 4'h1, 8'hFF, 4'h0, 4'h0, "fresh1");
    step(1'b0, 4'h1, 8'hFF, 4'h0, 4'h0, "fresh2");
    step(1'b0, 4'h1, 8'hFF, 4'h1, 4'h1, "fresh3");
    // reset while tick is high
    reset = 1'b1;
    #1;
    cmp("rst tick tick",  {28'd0, tick3},  32'd0);
    cmp("rst tick any",   {31'd0, any3},   32'd0);
    cmp("rst tick level", {28'd0, level3}, 32'd0);
    in3 = 4'h0;
    @(negedge clk);
    reset = 1'b0;

    // FILTER=1: toggling input ticks every cycle on both edges
    for (int k = 0; k < 8; k++) begin
      logic b;
      b = (k % 2 == 0);
      step(1'b1, {3'b000, b}, 8'hFF, 4'h1, {3'b000, b}, $sformatf("f1t%0d", k));
    end
    step(1'b1, 4'h0, 8'hFF, 4'h0, 4'h0, "f1idle");
    step(1'b1, 4'h1, 8'h01, 4'h1, 4'h1, "f1rise");
    step(1'b1, 4'h1, 8'h01, 4'h0, 4'h1, "f1hold");
    step(1'b1, 4'h0, 8'h01, 4'h0, 4'h0, "f1fall");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/multi_edge_tick.md
# multi_edge_tick

Parametrised, multi-channel edge-to-tick generator. It is the general form of the team's single-cycle tick blocks. Each of N independent input channels passes through a glitch filter. A programmable edge is then detected on the filtered level, and the block emits a one-clock-wide registered tick for it. It sits between raw button/switch/handshake inputs and the counters or FSMs that consume single-cycle events.

## Interface
- N, default 4: number of channels; legal range 1..32.
- FILTER, default 3: consecutive samples a new input value must hold before it is accepted; legal range 1..255. A value of 1 means no filtering.
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset; clears all state immediately.
- in  input  N  raw channel inputs; assumed already synchronous to clk.
- mode  input  2*N  per-channel edge select; bits [2i+1:2i] belong to channel i.
  - 00: off
  - 01: rising
  - 10: falling
  - 11: both
- tick  output  N  one-cycle pulse per accepted, mode-enabled edge.
- level  output  N  filtered (debounced) level per channel.
- any_tick  output  1  OR-reduction of tick.

## Operation
- Per-channel state: level bit, counter of width clog2(FILTER+1), and a 4-state FSM.
  - STABLE_LOW: level=0; counter=0.
  - RISE_PEND: level=0; in has been 1 for 1..FILTER-1 samples.
  - STABLE_HIGH: level=1; counter=0.
  - FALL_PEND: level=1; in has been 0 for 1..FILTER-1 samples.
- Each clock, for each channel:
  - in == level: counter clears, FSM returns to its STABLE state, no tick.
  - in != level and counter+1 < FILTER: counter increments, FSM enters or stays in PEND.
  - in != level and counter+1 == FILTER: edge accepted.
    - level inverts, counter clears, FSM enters the opposite STABLE state.
    - tick[i] is set for exactly the next cycle if mode[i] enables that edge direction.
- FILTER=1: the PEND states are never entered. Acceptance happens on the first differing sample.
- mode is sampled only at the acceptance edge. Changing mode never disturbs the filter, the level, or a pending count.
- mode=00: level still tracks the input; tick stays 0.
- Reset state:
  - every channel STABLE_LOW, counter 0;
  - level=0, tick=0, any_tick=0.
- If in=1 at reset release, that is treated as a rising edge once it passes the filter. A falling tick requires a prior accepted high level.
- Channels are fully independent. Any subset may tick in the same cycle.
- tick and level come directly from flops. any_tick is combinational from the tick flops only.

## Timing
- Input first differs from level at sampling edge e0 and holds through edge e0+FILTER-1:
  - level and tick rise at edge e0+FILTER-1;
  - tick falls at edge e0+FILTER;
  - latency is FILTER cycles from first sample to tick.
- A return to the old value before acceptance aborts the change. No tick, level unchanged, counter cleared.
- Minimum tick spacing per channel is FILTER cycles. With FILTER=1 and mode=11, a toggling input ticks every cycle.
- tick is never high for two consecutive cycles unless FILTER=1 and the input toggles every cycle.
- Asserting reset mid-PEND or while tick=1 drops tick, level and counter to 0 immediately, without waiting for a clock edge.

## Test plan
- **Reset with in=1:** N=4, FILTER=3, mode=all 11, in=4'b0001, release reset.
  - Expect level[0] and tick[0] rising 3 edges after release, tick[0] high exactly 1 cycle.
  - Other channels stay 0.
- **Glitch rejection:** FILTER=3, mode=01, in[1] pulses high for 2 cycles.
  - Expect no tick, level[1]=0, FSM back in STABLE_LOW.
  - Then hold in[1] high for 5 cycles: exactly one tick, 3 cycles after the rise.
- **Falling-only:** mode[5:4]=10, in[2] = clean high 6 cycles then low.
  - Expect no tick on the rise.
  - Expect one tick 3 cycles after the fall; level[2] follows both transitions.
- **Simultaneous channels:** all 4 channels rise on the same edge, mode=all 11.
  - Expect tick=4'b1111 for one cycle and any_tick=1 in that cycle.
- **Mid-count disturbances:**
  - Mode change mid-PEND: switch mode from 00 to 01 while a rise is pending. Expect the tick to fire at the normal acceptance edge.
  - Reset mid-PEND: assert reset during a pending rise. Expect immediate zeros and a fresh full FILTER delay after release.
- **FILTER=1, both edges:** mode=11, in[0] toggling every cycle for 8 cycles.
  - Expect tick[0]=1 on every cycle after the first sample; level[0] delayed 1 cycle from in[0].
